ps2_keyboard: RTL and testbench
===============================

# ps2_keyboard

PS/2 keyboard front end for the single-board computer. Receives scan-code set 2 frames from the keyboard pins and tracks modifier state. Drives the `keyCode` / `dataReady` / `shift` inputs consumed by the memory-mapped external device. Runs on `clk_50m`; `dataReady` is stretched so the slower pixel-clock CPU domain cannot miss it.

## Interface
- `FILTER_LEN`, 8: consecutive identical `ps2_clk` samples needed to accept a level change.
- `TIMEOUT_CYC`, 100000: idle cycles inside a frame before it is abandoned (2 ms at 50 MHz).
- `READY_STRETCH`, 4: cycles `dataReady` is held high per key event; legal range 1–15.
- `clk_50m`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, synchronous and active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `keyCode`  out  8  last make code; bit 7 set for E0-extended keys.
- `dataReady`  out  1  high for `READY_STRETCH` cycles per forwarded make code.
- `shift`  out  3  modifier state: [0] either Shift held, [1] Ctrl held, [2] Caps Lock latched.
- `frame_err`  out  1  one-cycle pulse on a discarded frame.

## Operation
- **Input conditioning**
  - Both pins pass through a 2-flop synchroniser.
  - `ps2_clk` is then filtered: the filtered level changes only after `FILTER_LEN` equal samples.
  - A bit is sampled on each filtered falling edge.
- **Receiver FSM** (IDLE, DATA, PARITY, STOP)
  - IDLE: on a falling edge with data 0 (start bit), go to DATA with bit count 0. Data 1 at start is ignored; stay in IDLE.
  - DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: data 1 delivers the byte to the decoder. Data 0 pulses `frame_err` and discards the byte. Either way, return to IDLE.
  - Timeout: an idle counter resets on every edge. Reaching `TIMEOUT_CYC` in any non-IDLE state returns to IDLE and pulses `frame_err`.
- **Decoder** (flags `ext`, `brk`; both cleared after any non-prefix byte)
  - E0: set `ext`.
  - F0: set `brk`.
  - E1: discarded; flags untouched.
  - 0x12 (LShift) and 0x59 (RShift): make/break sets/clears its own internal flag. `shift[0]` = LShift OR RShift.
  - 0x14 (Ctrl, with or without E0): make sets / break clears `shift[1]`.
  - 0x58 (Caps Lock): make toggles `shift[2]`; break has no effect. Typematic repeats of 0x58 make toggle again.
  - Any other make: `keyCode` = code, or {1, code[6:0]} if `ext`. `dataReady` is asserted.
  - Any other break: no output.
  - Modifier makes never assert `dataReady`.
- **Boundary cases**
  - New make while `dataReady` is high: `keyCode` updates and the stretch counter restarts.
  - Both Shift keys held, one released: `shift[0]` stays 1.
  - Reset mid-frame: receiver returns to IDLE, flags clear, partial byte is lost.
- **Reset values**: `keyCode` = 0, `dataReady` = 0, `shift` = 0, `frame_err` = 0.

## Timing
- Pin edge to internal edge detect: 2 (synchroniser) + `FILTER_LEN` cycles.
- Byte delivered the cycle after the stop-bit edge is detected.
- `keyCode`, `dataReady` and `shift` are registered, valid 1 cycle after byte delivery.
- `dataReady` is high for exactly `READY_STRETCH` consecutive cycles, then 0.
- `frame_err` is always exactly 1 cycle wide.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - STOP also checks odd parity over data + parity bit.
  - On mismatch the byte is discarded and `frame_err` pulses, with the same timing as a bad stop bit.
- Not defined: the parity bit is captured but ignored.

## Structure
- Package `ps2_pkg` holds:
  - Scan-code constants: `SC_EXT` 8'hE0, `SC_BREAK` 8'hF0, `SC_PAUSE` 8'hE1, `SC_LSHIFT` 8'h12, `SC_RSHIFT` 8'h59, `SC_CTRL` 8'h14, `SC_CAPS` 8'h58.
  - `shift` bit indices.
  - Receiver state enum.
- One sub-module, `ps2_rx`, covers synchroniser, filter, receiver FSM and timeout. It emits `byte_valid`/`byte_data`/`frame_err`.
- The decoder and output registers live in `ps2_keyboard`.

## Test plan
- Frame 0x1C (A) with correct parity, `READY_STRETCH`=4 -> `keyCode`=0x1C, `dataReady` high exactly 4 cycles, `shift`=000.
- Sequence 12, 1C, F0 1C, F0 12 -> `shift[0]` is 1 during 1C; exactly one `dataReady` (`keyCode`=0x1C); `shift[0]` returns to 0.
- Sequence E0 75 (up arrow) then E0 F0 75 -> `keyCode`=0xF5, one `dataReady`; break produces nothing.
- 58, F0 58, 58 -> `shift[2]` goes 1, stays 1, goes 0; `dataReady` never asserted.
- Frame with stop bit 0, then a frame aborted after 4 bits and left idle 100000 cycles -> two `frame_err` pulses, no `dataReady`, next good frame 0x29 decoded normally.
- With `PS2_PARITY_CHECK_EN`: 0x1C sent with even parity -> `frame_err` pulse, no `dataReady`. Without the macro: same frame -> `keyCode`=0x1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Scan-code set 2 values, shift-bit positions and the receiver state encoding.
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam int SH_SHIFT = 0;
   localparam int SH_CTRL  = 1;
   localparam int SH_CAPS  = 2;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, framing FSM, timeout.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not hold.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_sync, dat_sync;
   logic [FW-1:0] flt_cnt;
   logic          clk_flt, fall;

   // Filtered clock only moves after FILTER_LEN samples disagreeing with it.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         flt_cnt  <= '0;
         clk_flt  <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         fall     <= 1'b0;
         if (clk_sync[1] == clk_flt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_flt <= clk_sync[1];
            flt_cnt <= '0;
            fall    <= ~clk_sync[1];
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   rx_state_t     state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic [TW-1:0] idle_cnt;
   logic          valid_n, err_n, stop_ok, dat;

   assign dat = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
   logic par, par_n;
   assign stop_ok = dat & (^{shreg, par});
`else
   assign stop_ok = dat;
`endif

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      valid_n   = 1'b0;
      err_n     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_n     = par;
`endif
      if (fall) begin
         case (state)
            RX_IDLE: if (!dat) begin
               state_n   = RX_DATA;
               bit_cnt_n = 3'd0;
            end
            RX_DATA: begin
               shreg_n   = {dat, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = RX_PARITY;
            end
            RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_n   = dat;
`endif
               state_n = RX_STOP;
            end
            default: begin
               state_n = RX_IDLE;
               valid_n = stop_ok;
               err_n   = ~stop_ok;
            end
         endcase
      end else if (state != RX_IDLE && idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
         state_n = RX_IDLE;
         err_n   = 1'b1;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state      <= RX_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         idle_cnt   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         byte_valid <= valid_n;
         frame_err  <= err_n;
         idle_cnt   <= (fall || state == RX_IDLE) ? '0 : idle_cnt + 1'b1;
`ifdef PS2_PARITY_CHECK_EN
         par        <= par_n;
`endif
      end
   end

   assign byte_data = shreg;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: scan-code set 2 decoder, modifier tracking, stretched ready.
// Parity enforcement in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN    = 8,
   parameter int TIMEOUT_CYC   = 100000,
   parameter int READY_STRETCH = 4
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keyCode,
   output logic       dataReady,
   output logic [2:0] shift,
   output logic       frame_err
);

   logic       byte_valid;
   logic [7:0] byte_data;

   ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk_50m    (clk_50m),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   logic       ext, brk, lsh, rsh;
   logic       ext_n, brk_n, lsh_n, rsh_n, ctrl_n, caps_n, load;
   logic [3:0] rdy_cnt;

   always_comb begin
      ext_n  = ext;
      brk_n  = brk;
      lsh_n  = lsh;
      rsh_n  = rsh;
      ctrl_n = shift[SH_CTRL];
      caps_n = shift[SH_CAPS];
      load   = 1'b0;
      if (byte_valid) begin
         case (byte_data)
            SC_EXT:   ext_n = 1'b1;
            SC_BREAK: brk_n = 1'b1;
            SC_PAUSE: ;
            default: begin
               ext_n = 1'b0;
               brk_n = 1'b0;
               case (byte_data)
                  SC_LSHIFT: lsh_n  = ~brk;
                  SC_RSHIFT: rsh_n  = ~brk;
                  SC_CTRL:   ctrl_n = ~brk;
                  SC_CAPS:   if (!brk) caps_n = ~shift[SH_CAPS];
                  default:   load = ~brk;
               endcase
            end
         endcase
      end
   end

   // rdy_cnt counts the remaining high cycles after the first one.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         ext       <= 1'b0;
         brk       <= 1'b0;
         lsh       <= 1'b0;
         rsh       <= 1'b0;
         shift     <= '0;
         keyCode   <= '0;
         dataReady <= 1'b0;
         rdy_cnt   <= '0;
      end else begin
         ext             <= ext_n;
         brk             <= brk_n;
         lsh             <= lsh_n;
         rsh             <= rsh_n;
         shift[SH_SHIFT] <= lsh_n | rsh_n;
         shift[SH_CTRL]  <= ctrl_n;
         shift[SH_CAPS]  <= caps_n;
         if (load) begin
            keyCode   <= ext ? {1'b1, byte_data[6:0]} : byte_data;
            dataReady <= 1'b1;
            rdy_cnt   <= 4'(READY_STRETCH - 1);
         end else if (rdy_cnt != 4'd0) begin
            rdy_cnt <= rdy_cnt - 4'd1;
         end else begin
            dataReady <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed self-checking bench for ps2_keyboard; timeout shortened to keep the run brief.
module tb_ps2_keyboard;

   localparam int TMO  = 2000;
   localparam int HALF = 30;

   logic       clk_50m = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] keyCode;
   logic       dataReady;
   logic [2:0] shift;
   logic       frame_err;

   int n_checks = 0;
   int n_pass   = 0;

   ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .READY_STRETCH(4)) dut (
      .clk_50m   (clk_50m),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keyCode   (keyCode),
      .dataReady (dataReady),
      .shift     (shift),
      .frame_err (frame_err)
   );

   always #10 clk_50m = ~clk_50m;

   // Event monitor sampled on the falling edge.
   int         dr_events = 0, dr_run = 0, last_run = 0;
   int         err_events = 0, err_run = 0, err_run_max = 0;
   logic [7:0] kc_at_dr = 8'h00;
   logic [2:0] sh_at_dr = 3'b000;
   logic       dr_prev = 1'b0;

   always @(negedge clk_50m) begin
      if (dataReady && !dr_prev) begin
         dr_events = dr_events + 1;
         kc_at_dr  = keyCode;
         sh_at_dr  = shift;
      end
      if (dataReady) dr_run = dr_run + 1;
      else if (dr_run != 0) begin
         last_run = dr_run;
         dr_run   = 0;
      end
      dr_prev = dataReady;
      if (frame_err) begin
         err_run = err_run + 1;
         if (err_run == 1) err_events = err_events + 1;
         if (err_run > err_run_max) err_run_max = err_run;
      end else err_run = 0;
   end

   task automatic send_frame(input logic [7:0] d, input bit bad_stop = 0,
                             input bit bad_par = 0, input int nbits = 11);
      logic [10:0] bits;
      logic        p;
      p    = bad_par ? ^d : ~^d;
      bits = {~bad_stop, p, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk_50m);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk_50m);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (HALF + 10) @(posedge clk_50m);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (5) @(posedge clk_50m);
      rst = 1'b0;
      @(negedge clk_50m);
      n_checks++;
      if (keyCode !== 8'h00) $display("FAIL reset_keyCode got %h want 00", keyCode); else n_pass++;
      n_checks++;
      if (dataReady !== 1'b0) $display("FAIL reset_dataReady got %b want 0", dataReady); else n_pass++;
      n_checks++;
      if (shift !== 3'b000) $display("FAIL reset_shift got %b want 000", shift); else n_pass++;
      n_checks++;
      if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else n_pass++;
   endtask

   task automatic test_single;
      int d0;
      d0 = dr_events;
      send_frame(8'h1C);
      n_checks++;
      if (dr_events - d0 !== 1) $display("FAIL single_events got %0d want 1", dr_events - d0); else n_pass++;
      n_checks++;
      if (kc_at_dr !== 8'h1C) $display("FAIL single_keyCode got %h want 1c", kc_at_dr); else n_pass++;
      n_checks++;
      if (last_run !== 4) $display("FAIL single_stretch got %0d want 4", last_run); else n_pass++;
      n_checks++;
      if (shift !== 3'b000) $display("FAIL single_shift got %b want 000", shift); else n_pass++;
   endtask

   task automatic test_shift;
      int d0;
      d0 = dr_events;
      send_frame(8'h12);
      n_checks++;
      if (shift !== 3'b001) $display("FAIL shift_make got %b want 001", shift); else n_pass++;
      send_frame(8'h1C);
      send_frame(8'hF0); send_frame(8'h1C);
      send_frame(8'hF0); send_frame(8'h12);
      n_checks++;
      if (dr_events - d0 !== 1) $display("FAIL shift_events got %0d want 1", dr_events - d0); else n_pass++;
      n_checks++;
      if (sh_at_dr[0] !== 1'b1) $display("FAIL shift_during_key got %b want 1", sh_at_dr[0]); else n_pass++;
      n_checks++;
      if (kc_at_dr !== 8'h1C) $display("FAIL shift_keyCode got %h want 1c", kc_at_dr); else n_pass++;
      n_checks++;
      if (shift !== 3'b000) $display("FAIL shift_release got %b want 000", shift); else n_pass++;
   endtask

   task automatic test_both_shift;
      send_frame(8'h12); send_frame(8'h59);
      send_frame(8'hF0); send_frame(8'h12);
      n_checks++;
      if (shift !== 3'b001) $display("FAIL both_shift_one_up got %b want 001", shift); else n_pass++;
      send_frame(8'hF0); send_frame(8'h59);
      n_checks++;
      if (shift !== 3'b000) $display("FAIL both_shift_all_up got %b want 000", shift); else n_pass++;
   endtask

   task automatic test_ctrl;
      int d0;
      d0 = dr_events;
      send_frame(8'hE0); send_frame(8'h14);
      n_checks++;
      if (shift !== 3'b010) $display("FAIL ctrl_make got %b want 010", shift); else n_pass++;
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h14);
      n_checks++;
      if (shift !== 3'b000) $display("FAIL ctrl_break got %b want 000", shift); else n_pass++;
      n_checks++;
      if (dr_events != d0) $display("FAIL ctrl_no_ready got %0d want 0", dr_events - d0); else n_pass++;
   endtask

   task automatic test_ext;
      int d0;
      d0 = dr_events;
      send_frame(8'hE0); send_frame(8'h75);
      n_checks++;
      if (kc_at_dr !== 8'hF5) $display("FAIL ext_keyCode got %h want f5", kc_at_dr); else n_pass++;
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
      n_checks++;
      if (dr_events - d0 !== 1) $display("FAIL ext_events got %0d want 1", dr_events - d0); else n_pass++;
      // E1 between E0 and the code must leave the extended flag intact
      send_frame(8'hE0); send_frame(8'hE1); send_frame(8'h6B);
      n_checks++;
      if (kc_at_dr !== 8'hEB) $display("FAIL pause_keeps_ext got %h want eb", kc_at_dr); else n_pass++;
      send_frame(8'h6B);
      n_checks++;
      if (kc_at_dr !== 8'h6B) $display("FAIL ext_cleared got %h want 6b", kc_at_dr); else n_pass++;
   endtask

   task automatic test_caps;
      int d0;
      d0 = dr_events;
      send_frame(8'h58);
      n_checks++;
      if (shift !== 3'b100) $display("FAIL caps_on got %b want 100", shift); else n_pass++;
      send_frame(8'hF0); send_frame(8'h58);
      n_checks++;
      if (shift !== 3'b100) $display("FAIL caps_break got %b want 100", shift); else n_pass++;
      send_frame(8'h58);
      n_checks++;
      if (shift !== 3'b000) $display("FAIL caps_off got %b want 000", shift); else n_pass++;
      n_checks++;
      if (dr_events != d0) $display("FAIL caps_no_ready got %0d want 0", dr_events - d0); else n_pass++;
   endtask

   task automatic test_errors;
      int d0, e0;
      d0 = dr_events;
      e0 = err_events;
      send_frame(8'h33, 1'b1);
      n_checks++;
      if (err_events - e0 !== 1) $display("FAIL bad_stop_err got %0d want 1", err_events - e0); else n_pass++;
      send_frame(8'h33, 1'b0, 1'b0, 5);
      repeat (TMO + 200) @(posedge clk_50m);
      n_checks++;
      if (err_events - e0 !== 2) $display("FAIL timeout_err got %0d want 2", err_events - e0); else n_pass++;
      n_checks++;
      if (err_run_max !== 1) $display("FAIL err_width got %0d want 1", err_run_max); else n_pass++;
      n_checks++;
      if (dr_events != d0) $display("FAIL err_no_ready got %0d want 0", dr_events - d0); else n_pass++;
      send_frame(8'h29);
      n_checks++;
      if (kc_at_dr !== 8'h29 || dr_events - d0 !== 1)
         $display("FAIL after_err_keyCode got %h/%0d want 29/1", kc_at_dr, dr_events - d0);
      else n_pass++;
   endtask

   task automatic test_parity;
      int d0, e0;
      d0 = dr_events;
      e0 = err_events;
      send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      n_checks++;
      if (err_events - e0 !== 1) $display("FAIL parity_err got %0d want 1", err_events - e0); else n_pass++;
      n_checks++;
      if (dr_events != d0) $display("FAIL parity_no_ready got %0d want 0", dr_events - d0); else n_pass++;
`else
      n_checks++;
      if (err_events != e0) $display("FAIL parity_ignored_err got %0d want 0", err_events - e0); else n_pass++;
      n_checks++;
      if (kc_at_dr !== 8'h1C || dr_events - d0 !== 1)
         $display("FAIL parity_ignored_key got %h/%0d want 1c/1", kc_at_dr, dr_events - d0);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid_frame;
      send_frame(8'hE0);
      send_frame(8'h58);
      send_frame(8'h1C, 1'b0, 1'b0, 5);
      @(posedge clk_50m);
      rst = 1'b1;
      repeat (3) @(posedge clk_50m);
      rst = 1'b0;
      @(negedge clk_50m);
      n_checks++;
      if (shift !== 3'b000) $display("FAIL rst_mid_shift got %b want 000", shift); else n_pass++;
      send_frame(8'h75);
      n_checks++;
      if (kc_at_dr !== 8'h75) $display("FAIL rst_mid_keyCode got %h want 75", kc_at_dr); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_shift();
      test_both_shift();
      test_ctrl();
      test_ext();
      test_caps();
      test_errors();
      test_parity();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
